// File: rtl/uart_rx_edge_sampler.sv
// UART RX oversampling front end: edge/bit counters plus a three-sample mid-bit majority vote.
// Define UART_RX_SYNC_EN to put a two-flop synchronizer (reset to 1) in front of the sampler.
module uart_rx_edge_sampler #(
  parameter int PRESC_W = 6,
  parameter int BITC_W  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               EDGE_CNT_en,
  input  logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_count,
  output logic [BITC_W-1:0]  bit_count,
  output logic               sampled_bit,
  output logic               sample_valid
);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [BITC_W-1:0] sat_inc(input logic [BITC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic line;

`ifdef UART_RX_SYNC_EN
  logic rx_p0;
  logic rx_p1;

  // Stage p0/p1: metastability synchronizer, idles at the line's mark level
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= RX_IN;
      rx_p1 <= rx_p0;
    end
  end

  assign line = rx_p1;
`else
  assign line = RX_IN;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_count <= '0;
      bit_count  <= BITC_W'(1);
    end else if (!EDGE_CNT_en) begin
      edge_count <= '0;
      bit_count  <= BITC_W'(1);
    end else if (prescale < PRESC_W'(2)) begin
      edge_count <= '0;
    end else if (edge_count == prescale) begin
      edge_count <= PRESC_W'(1);
      bit_count  <= sat_inc(bit_count);
    end else begin
      edge_count <= edge_count + 1'b1;
    end
  end

  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] pt0;
  logic [PRESC_W-1:0] pt2;

  assign half = prescale >> 1;
  assign pt0  = half - PRESC_W'(1);
  assign pt2  = half + PRESC_W'(1);

  logic s0;
  logic s1;
  logic got0;
  logic got1;

  // The third sample is voted straight from the line at its capture edge, so the
  // result lands one cycle after that edge. got0/got1 abort the vote if sampling
  // is withdrawn anywhere inside the three-sample window.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      got0         <= 1'b0;
      got1         <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!dat_samp_en) begin
        got0 <= 1'b0;
        got1 <= 1'b0;
      end else begin
        if (edge_count == pt0) begin
          s0   <= line;
          got0 <= 1'b1;
        end
        if (edge_count == half) begin
          s1   <= line;
          got1 <= got0;
        end
        if (edge_count == pt2) begin
          if (got1) begin
            sampled_bit  <= maj3(s0, s1, line);
            sample_valid <= 1'b1;
          end
          got0 <= 1'b0;
          got1 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Scoreboard bench for uart_rx_edge_sampler: stimulus queues expected votes, a monitor checks them.
module tb_uart_rx_edge_sampler;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       EDGE_CNT_en = 1'b0;
  logic       dat_samp_en = 1'b0;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sample_valid;

  uart_rx_edge_sampler #(.PRESC_W(6), .BITC_W(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .prescale(prescale),
    .EDGE_CNT_en(EDGE_CNT_en),
    .dat_samp_en(dat_samp_en),
    .edge_count(edge_count),
    .bit_count(bit_count),
    .sampled_bit(sampled_bit),
    .sample_valid(sample_valid)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit exp_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every vote pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (RST === 1'b1 && sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vote: sample_valid=1 sampled_bit=%0b, expected no vote (t=%0t)",
                 sampled_bit, $time);
      end else begin
        exp_head = exp_q.pop_front();
        chk("vote", 32'(sampled_bit), 32'(exp_head));
      end
    end
  end

  // low_at[v]=1 means the line value captured while edge_count==v is 0.
  task automatic run_bit(input int ps, input logic [63:0] low_at, input int off_at,
                         input bit expect_vote, input bit exp);
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1; prescale = ps[5:0];
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b1; dat_samp_en = 1'b1;
    if (expect_vote) exp_q.push_back(exp);
    RX_IN = ~low_at[LAT];
    for (int c = 1; c <= ps; c++) begin
      @(posedge CLK); #1;
      if (c == off_at) dat_samp_en = 1'b0;
      RX_IN = ~low_at[c + LAT];
    end
    @(posedge CLK); #1;
    dat_samp_en = 1'b0; RX_IN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] frame;
    frame = {1'b1, 8'h5A, 1'b0};

    // Reset with the line held low
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_edge_count", 32'(edge_count), 0);
    chk("rst_bit_count", 32'(bit_count), 1);
    chk("rst_sampled_bit", 32'(sampled_bit), 1);
    chk("rst_sample_valid", 32'(sample_valid), 0);
    @(posedge CLK); #1;
    RST = 1'b1; RX_IN = 1'b1;
    @(posedge CLK); #1;

    // Full frame 0x5A, prescale 8
    prescale = 6'd8;
    EDGE_CNT_en = 1'b1; dat_samp_en = 1'b1; RX_IN = frame[0];
    for (int k = 0; k < 10; k++) exp_q.push_back(frame[k]);
    for (int n = 1; n <= 80; n++) begin
      @(posedge CLK); #1;
      if (n % 8 == 0 && n < 80) RX_IN = frame[n / 8];
      @(negedge CLK);
      chk("frame_edge_count", 32'(edge_count), ((n - 1) % 8) + 1);
      chk("frame_bit_count", 32'(bit_count), ((n - 1) / 8) + 1);
      chk("frame_valid_at_6", 32'(sample_valid), (((n - 1) % 8) + 1 == 6) ? 1 : 0);
    end
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1;

    // Glitch rejection at prescale 16: samples at edge_count 7, 8, 9
    run_bit(16, 64'h180, 0, 1'b1, 1'b0);
    run_bit(16, 64'h100, 0, 1'b1, 1'b1);
    run_bit(16, 64'h200, 0, 1'b1, 1'b1);

    // Line-latency boundary: low from the s2 point only, then from the s0 point
    run_bit(8, 64'h7E0, 0, 1'b1, 1'b1);
    run_bit(8, 64'h7F8, 0, 1'b1, 1'b0);

    // Reset during a vote window discards the vote
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b0; dat_samp_en = 1'b0; prescale = 6'd8; RX_IN = 1'b0;
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b1; dat_samp_en = 1'b1;
    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1; EDGE_CNT_en = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1;
    @(negedge CLK);
    chk("midrst_edge_count", 32'(edge_count), 0);
    chk("midrst_bit_count", 32'(bit_count), 1);
    chk("midrst_sampled_bit", 32'(sampled_bit), 1);
    chk("midrst_sample_valid", 32'(sample_valid), 0);

    // Sampling withdrawn after the s0 capture: no vote, bit held
    run_bit(8, 64'h0, 0, 1'b1, 1'b1);
    run_bit(8, {64{1'b1}}, 4, 1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("abort_hold_bit", 32'(sampled_bit), 1);
    chk("abort_no_valid", 32'(sample_valid), 0);

    // prescale 32 restart at bit 10, edge 32
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b0; prescale = 6'd32;
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b1;
    for (int n = 1; n <= 320; n++) begin
      @(posedge CLK); #1;
      if (n == 320) EDGE_CNT_en = 1'b0;
      @(negedge CLK);
      if (n == 32 || n == 33 || n == 320) begin
        chk("p32_edge_count", 32'(edge_count), ((n - 1) % 32) + 1);
        chk("p32_bit_count", 32'(bit_count), ((n - 1) / 32) + 1);
      end
    end
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b1;
    @(negedge CLK);
    chk("restart_edge_zero", 32'(edge_count), 0);
    chk("restart_bit_one", 32'(bit_count), 1);
    @(posedge CLK);
    @(negedge CLK);
    chk("restart_edge_one", 32'(edge_count), 1);
    chk("restart_bit_still_one", 32'(bit_count), 1);

    // Guard: prescale 0 freezes edge_count at 0 and holds bit_count
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b0; prescale = 6'd4;
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("guard_pre_edge", 32'(edge_count), 2);
    chk("guard_pre_bit", 32'(bit_count), 2);
    @(posedge CLK); #1;
    prescale = 6'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("guard_edge_zero", 32'(edge_count), 0);
    chk("guard_bit_hold", 32'(bit_count), 2);

    // Saturation: prescale 4 for 80 cycles
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b0; prescale = 6'd4;
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b1;
    repeat (80) @(posedge CLK);
    @(negedge CLK);
    chk("sat_bit_count", 32'(bit_count), 15);
    chk("sat_edge_count", 32'(edge_count), 4);
    @(posedge CLK); #1;
    EDGE_CNT_en = 1'b0;

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("votes_outstanding", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_edge_sampler.md
# uart_rx_edge_sampler

Oversampling front end of the UART receiver, directly upstream of the RX control FSM. It counts oversampling clock edges within each bit period and bits within a frame, producing the `edge_count` and `bit_count` values the FSM compares against `prescale`. It also takes a three-sample majority vote at mid-bit to produce the recovered serial bit consumed by the start, parity and stop checkers and the deserializer.

## Interface
Parameters:
- `PRESC_W`, 6: width of `prescale` and `edge_count`.
- `BITC_W`, 4: width of `bit_count`.

Ports:
- `CLK`  in  1  oversampling clock, `prescale` cycles per UART bit.
- `RST`  in  1  reset, synchronous, active-low.
- `RX_IN`  in  1  serial line; idles high.
- `prescale`  in  PRESC_W  oversampling ratio. Legal values are even numbers 4..32; 8, 16 and 32 are the supported production values.
- `EDGE_CNT_en`  in  1  counter enable from the FSM.
- `dat_samp_en`  in  1  sampling enable from the FSM.
- `edge_count`  out  PRESC_W  edge index within the current bit, 1..prescale; 0 while disabled.
- `bit_count`  out  BITC_W  bit index within the frame: 1 = start, 2..9 = data, 10 = parity or stop, 11 = stop.
- `sampled_bit`  out  1  majority-voted bit value for the current bit.
- `sample_valid`  out  1  one-cycle pulse when `sampled_bit` updates.

## Operation
- **Reset** (`RST`=0 at a `CLK` edge):
  - `edge_count`=0, `bit_count`=1.
  - `sampled_bit`=1, `sample_valid`=0.
  - Sample registers s0, s1 and s2 are set to 1.
- **Counter with `EDGE_CNT_en`=0:** `edge_count`←0 and `bit_count`←1 on every clock. This is how the FSM restarts a frame back-to-back.
- **Counter with `EDGE_CNT_en`=1:**
  - If `edge_count`==`prescale`: `edge_count`←1, `bit_count`←`bit_count`+1. `bit_count` saturates at 15 and never wraps.
  - Otherwise `edge_count`←`edge_count`+1.
- **Guard:** if `prescale`<2, `edge_count` holds at 0 and `bit_count` holds its value.
- **Sample points:** H = `prescale`>>1. With `dat_samp_en`=1, the line value (`RX_IN`, or its synchronized version, see Configuration) is captured as follows:
  - into s0 when `edge_count`==H−1,
  - into s1 when `edge_count`==H,
  - into s2 when `edge_count`==H+1.
- **Vote:** in the cycle after the s2 capture, `sampled_bit`←majority(s0,s1,s2) and `sample_valid`=1 for exactly that cycle.
- **Hold:** `sampled_bit` holds its value until the next vote.
- **Sampling disabled:** with `dat_samp_en`=0, no captures occur and `sample_valid` stays 0. `sampled_bit` holds its value, and the counters still obey `EDGE_CNT_en`.
- **Mid-window disable:** if `dat_samp_en` drops between the s0 and s2 captures, no vote occurs for that bit.
- **Arithmetic:** all compares are unsigned at PRESC_W bits. H+1 never exceeds `prescale` for legal values.

## Timing
- Counters are registered, so outputs change one cycle after the enable condition.
- With `EDGE_CNT_en` asserted at cycle 0, `edge_count`=1 at cycle 1 and `edge_count`=`prescale` at cycle `prescale`.
  - At cycle `prescale`+1, `edge_count`=1 and `bit_count`=2.
- `sampled_bit` and `sample_valid` appear at `edge_count`==H+2, which is well before the FSM's `edge_count`==`prescale` decision.
- Reset mid-frame: all outputs take their reset values on the next edge; any in-progress vote is discarded.
- Changing `prescale` mid-frame is unsupported. If `edge_count` ends up above a new `prescale`, it continues incrementing up to its PRESC_W-bit maximum and wraps to 0.

## Configuration
- **`UART_RX_SYNC_EN` defined:**
  - `RX_IN` passes through a two-flop synchronizer, reset to 1, before sampling.
  - The sampling path adds 2 cycles of latency; sample points are unchanged relative to `edge_count`.
- **Undefined:** `RX_IN` is sampled directly. Use only when `RX_IN` is already synchronous to `CLK`.

## Test plan
- **Reset:** assert `RST`=0 for 3 cycles with `RX_IN`=0 → `edge_count`=0, `bit_count`=1, `sampled_bit`=1, `sample_valid`=0.
- **Full frame, prescale=8:** send 0x5A with no parity, holding `EDGE_CNT_en` high from the start bit.
  - `bit_count` steps 1→10, each value lasting 8 cycles; `edge_count` cycles 1..8.
  - `sample_valid` pulses at `edge_count`==6, and the voted bits are 0, 0,1,0,1,1,0,1,0 (LSB first), then 1.
- **Glitch rejection, prescale=16:** drive `RX_IN` low only at `edge_count`==8 within a high bit → `sampled_bit`=1. Drive it low at `edge_count`==7 and 8 → `sampled_bit`=0.
- **prescale=32 restart:** drop `EDGE_CNT_en` for 1 cycle at `bit_count`=10, `edge_count`=32 → next cycle `edge_count`=0 and `bit_count`=1; re-enable and `edge_count`=1 follows.
- **Saturation and guard:**
  - Hold `EDGE_CNT_en`=1 with prescale=4 for 80 cycles → `bit_count` stops at 15.
  - Set prescale=0 → `edge_count` stays 0.
- **Sync latency:** with `UART_RX_SYNC_EN` defined, step `RX_IN` low 1 cycle before the s0 capture point → the vote still reads the prior value 1. Step it 3 cycles before → vote = 0.
